// File: rtl/bp_fe_queue_rolly.sv
// Checkpointing FIFO between fetch and the back-end checker.
// Entries stay resident until committed so a flush can replay them.
module bp_fe_queue_rolly #(
    parameter int width_p = 104,
    parameter int els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] fe_queue_i,
    input  logic               fe_queue_v_i,
    output logic               fe_queue_ready_o,
    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,
    input  logic               fe_queue_clr_i,
    input  logic               fe_queue_deq_i,
    input  logic               fe_queue_roll_i
);

    localparam int lg_lp    = $clog2(els_p);
    localparam int ptr_w_lp = lg_lp + 1;

    typedef logic [ptr_w_lp-1:0] ptr_t;

    localparam ptr_t els_ptr_lp = ptr_t'(els_p);

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    ptr_t cptr_q, cptr_d;
    ptr_t r1;

    logic [width_p-1:0] mem_q [els_p];

    logic full, empty;
    logic enq, yumi_v, mem_we;

    // Wrap bit separates full from empty, so no special case at els_p
    assign full  = (wptr_q - cptr_q) == els_ptr_lp;
    assign empty = (rptr_q == wptr_q);

    assign fe_queue_ready_o = ~full;
    assign fe_queue_v_o     = ~empty;
    assign fe_queue_o       = mem_q[rptr_q[lg_lp-1:0]];

    assign enq    = fe_queue_v_i & ~full;
    assign yumi_v = fe_queue_yumi_i & ~empty & ~fe_queue_roll_i;
    assign r1     = rptr_q + ptr_t'(yumi_v);
    assign mem_we = enq & ~fe_queue_clr_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = r1;
        cptr_d = cptr_q;
        if (fe_queue_roll_i) begin
            rptr_d = cptr_q;
        end else if (fe_queue_deq_i) begin
            cptr_d = r1;
        end
        if (fe_queue_clr_i) begin
            wptr_d = fe_queue_roll_i ? cptr_q : r1;
        end else if (enq) begin
            wptr_d = wptr_q + ptr_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wptr_q[lg_lp-1:0]] <= fe_queue_i;
        end
    end

    a_no_yumi_empty: assert property (
        @(posedge clk_i) disable iff (reset_i)
        fe_queue_yumi_i |-> fe_queue_v_o
    );

    a_ptr_order: assert property (
        @(posedge clk_i) disable iff (reset_i)
        ((rptr_q - cptr_q) <= (wptr_q - cptr_q))
        && ((wptr_q - cptr_q) <= els_ptr_lp)
    );

endmodule

// File: tb/tb_bp_fe_queue_rolly.sv
// Bench for bp_fe_queue_rolly: directed scenarios plus random traffic
// checked against a queue-based model every cycle.
module tb_bp_fe_queue_rolly;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [15:0] din;
    logic        vin, ready, vout;
    logic [15:0] dout;
    logic        yumi, clr, deq, roll;

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 0;

    bp_fe_queue_rolly #(.width_p(16), .els_p(8)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .fe_queue_i      (din),
        .fe_queue_v_i    (vin),
        .fe_queue_ready_o(ready),
        .fe_queue_o      (dout),
        .fe_queue_v_o    (vout),
        .fe_queue_yumi_i (yumi),
        .fe_queue_clr_i  (clr),
        .fe_queue_deq_i  (deq),
        .fe_queue_roll_i (roll)
    );

    always #5 clk = ~clk;

    // Model: list of uncommitted entries, rd = how many of them were read
    logic [15:0] mq[$];
    int          rd = 0;

    function automatic bit m_v();
        return rd < mq.size();
    endfunction

    function automatic bit m_ready();
        return mq.size() < 8;
    endfunction

    always @(posedge clk) begin
        bit en, yv;
        if (reset_i) begin
            mq.delete();
            rd = 0;
        end else begin
            en = vin && m_ready();
            yv = yumi && m_v() && !roll;
            if (roll) begin
                rd = 0;
                if (clr) mq.delete();
            end else begin
                rd = rd + int'(yv);
                if (clr)
                    while (mq.size() > rd) void'(mq.pop_back());
                if (deq) begin
                    repeat (rd) void'(mq.pop_front());
                    rd = 0;
                end
            end
            if (en && !clr) mq.push_back(din);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            n_chk++;
            if (ready !== m_ready()) begin
                n_fail++;
                $display("FAIL model_ready got %b want %b @%0t",
                         ready, m_ready(), $time);
            end
            n_chk++;
            if (vout !== m_v()) begin
                n_fail++;
                $display("FAIL model_v got %b want %b @%0t",
                         vout, m_v(), $time);
            end
            if (m_v()) begin
                n_chk++;
                if (dout !== mq[rd]) begin
                    n_fail++;
                    $display("FAIL model_data got %h want %h @%0t",
                             dout, mq[rd], $time);
                end
            end
        end
    end

    task automatic lit(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h @%0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the edge
    task automatic cyc(input bit e, input logic [15:0] d, input bit y,
                       input bit dq, input bit rl, input bit cl,
                       input bit rs);
        vin = e; din = d; yumi = y; deq = dq;
        roll = rl; clr = cl; reset_i = rs;
        @(posedge clk);
        #1;
        vin = 0; yumi = 0; deq = 0; roll = 0; clr = 0; reset_i = 0;
    endtask

    task automatic rst();
        cyc(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic enq(input logic [15:0] d);
        cyc(1, d, 0, 0, 0, 0, 0);
    endtask

    task automatic pop();
        cyc(0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        reset_i = 1; vin = 0; din = 0; yumi = 0;
        deq = 0; roll = 0; clr = 0;
        @(posedge clk);
        #1;
        reset_i = 0;
        started = 1;
        lit("reset_ready", 16'(ready), 16'd1);
        lit("reset_v", 16'(vout), 16'd0);

        // 1: fill, overflow drop, drain, commit
        for (int i = 1; i <= 8; i++) enq(16'(i));
        lit("t1_full", 16'(ready), 16'd0);
        enq(16'h0009);
        lit("t1_head", dout, 16'h0001);
        for (int i = 1; i <= 8; i++) begin
            lit("t1_order", dout, 16'(i));
            pop();
        end
        lit("t1_v_empty", 16'(vout), 16'd0);
        lit("t1_still_full", 16'(ready), 16'd0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        lit("t1_deq_ready", 16'(ready), 16'd1);

        // 2: roll replays everything read
        rst();
        enq(16'h000A); enq(16'h000B); enq(16'h000C);
        pop(); pop();
        cyc(0, 0, 0, 0, 1, 0, 0);
        lit("t2_roll_head", dout, 16'h000A);
        lit("t2_replay_a", dout, 16'h000A); pop();
        lit("t2_replay_b", dout, 16'h000B); pop();
        lit("t2_replay_c", dout, 16'h000C); pop();
        lit("t2_drained", 16'(vout), 16'd0);

        // 3: popped-and-committed entries are not replayed
        rst();
        enq(16'h000A); enq(16'h000B); enq(16'h000C);
        cyc(0, 0, 1, 1, 0, 0, 0);
        pop();
        cyc(0, 0, 0, 0, 1, 0, 0);
        lit("t3_roll_head", dout, 16'h000B);

        // 4: clear drops unread entries and a concurrent enqueue
        rst();
        enq(16'h000A); enq(16'h000B); enq(16'h000C); enq(16'h000D);
        pop();
        cyc(1, 16'h000E, 0, 0, 0, 1, 0);
        lit("t4_clr_v", 16'(vout), 16'd0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        lit("t4_roll_v", 16'(vout), 16'd1);
        lit("t4_roll_head", dout, 16'h000A);
        pop();
        lit("t4_after_a", 16'(vout), 16'd0);

        // 5: steady streaming across the wrap point
        rst();
        enq(16'h0000);
        for (int c = 1; c <= 20; c++) begin
            lit("t5_ready", 16'(ready), 16'd1);
            lit("t5_data", dout, 16'(c - 1));
            cyc(1, 16'(c), 1, 1, 0, 0, 0);
        end
        lit("t5_last", dout, 16'd20);

        // 6: reset mid-operation
        rst();
        for (int i = 0; i < 5; i++) enq(16'(16'h0100 + i));
        pop(); pop();
        rst();
        lit("t6_v", 16'(vout), 16'd0);
        lit("t6_ready", 16'(ready), 16'd1);
        enq(16'h5A5A);
        lit("t6_new_head", dout, 16'h5A5A);

        // Random traffic against the model
        rst();
        for (int n = 0; n < 4000; n++) begin
            bit e, y, dq, rl, cl, rs;
            e  = ($urandom_range(0, 2) != 0);
            y  = m_v() && ($urandom_range(0, 2) != 0);
            dq = ($urandom_range(0, 4) == 0);
            rl = ($urandom_range(0, 15) == 0);
            cl = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 299) == 0);
            cyc(e, 16'($urandom), y, dq, rl, cl, rs);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
